// File: rtl/lsu_handshake_pkg.sv
// Shared constants for the load/store unit and its helpers.
// State encoding stays plain localparams for older tooling.
package lsu_handshake_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] RD_ABORT    = 32'h0;
    localparam int          TIMEOUT_DEF = 16;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_handshake_if.sv
// Req/ack data-memory bus between the LSU (master) and memory (slave).
// One transaction per request; ack is a single-cycle pulse.
interface lsu_handshake_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_timeout_ctr.sv
// Clearable, enabled up-counter with a terminal-count flag at LIMIT-1.
// Generic enough to guard any req/ack bus, data or instruction side.
module lsu_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/lsu_handshake.sv
// LSU bridge: single-cycle core data port to a req/ack data memory.
// Stalls the core for the life of each bus transaction.
import lsu_handshake_pkg::*;

module lsu_handshake #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [AW-1:0]   Addr,
    input  logic [DW-1:0]   Din,
    output logic [DW-1:0]   Dout,
    output logic            Stall,
    output logic            AlignErr,
    output logic            BusErr,
    lsu_handshake_if.master mem
);
    logic [1:0] state;
    logic       access;
    logic       aligned;
    logic       conflict;
    logic       tmo_tc;
    logic       ctr_clr;
    logic       ctr_en;

    assign access   = MemRead | MemWrite;
    assign aligned  = is_aligned(Addr[1:0]);
    assign conflict = MemRead & MemWrite;

    // Counter only runs while a request is outstanding.
    assign ctr_clr = (state != REQ);
    assign ctr_en  = (state == REQ) & ~mem.mem_ack & ~tmo_tc;

    assign Stall = ~reset
                 & (((state == IDLE) & access & aligned)
                 | (state == REQ));

    lsu_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_tmo (
        .clock(clock),
        .reset(reset),
        .clr  (ctr_clr),
        .en   (ctr_en),
        .tc   (tmo_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            Dout          <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            AlignErr      <= 1'b0;
            BusErr        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        if (conflict) begin
                            BusErr <= 1'b1;
                        end
                        if (aligned) begin
                            state         <= REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= MemWrite;
                            mem.mem_addr  <= {Addr[AW-1:2], 2'b00};
                            mem.mem_wdata <= Din;
                        end else begin
                            // No bus cycle: store dropped, load keeps Dout.
                            state    <= DONE;
                            AlignErr <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) begin
                            Dout <= mem.mem_rdata;
                        end
                    end else if (tmo_tc) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                        BusErr      <= 1'b1;
                        if (!mem.mem_we) begin
                            Dout <= DW'(RD_ABORT);
                        end
                    end
                end
                // One unstalled cycle so the core commits exactly once.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed plus randomized checks of lsu_handshake against a
// per-access reference model and a req/ack memory responder.
module tb_lsu_handshake;
    import lsu_handshake_pkg::*;

    localparam int TO = 4;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        MemRead  = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr     = '0;
    logic [31:0] Din      = '0;
    logic [31:0] Dout;
    logic        Stall;
    logic        AlignErr;
    logic        BusErr;

    lsu_handshake_if #(.AW(32), .DW(32)) bus ();

    lsu_handshake #(
        .AW(32),
        .DW(32),
        .TIMEOUT(TO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .Addr    (Addr),
        .Din     (Din),
        .Dout    (Dout),
        .Stall   (Stall),
        .AlignErr(AlignErr),
        .BusErr  (BusErr),
        .mem     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Bus transactions are counted on rising edges of mem_req.
    int   txn   = 0;
    logic req_q = 1'b0;
    always @(posedge clock) begin
        if (bus.mem_req && !req_q) txn <= txn + 1;
        req_q <= bus.mem_req;
    end

    // Reference model state.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] m_dout  = '0;
    logic        m_align = 1'b0;
    logic        m_bus   = 1'b0;

    function automatic logic [31:0] deflt(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One processor access; memory acks after `waits` REQ cycles.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input int waits, input string tag);
        int          stalls;
        int          reqs;
        int          t0;
        int          exp_req;
        bit          acc;
        bit          al;
        bit          tmo;
        logic        cap_we;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [31:0] rv;
        stalls    = 0;
        reqs      = 0;
        cap_we    = 1'b0;
        cap_addr  = '0;
        cap_wdata = '0;
        acc = rd | wr;
        al  = (a[1:0] == 2'b00);
        tmo = acc && al && (waits >= TO);
        exp_req = (acc && al) ? ((waits < TO) ? waits + 1 : TO) : 0;
        if (acc && !al) m_align = 1'b1;
        if (rd && wr) m_bus = 1'b1;
        if (tmo) m_bus = 1'b1;
        if (acc && al) begin
            if (wr) begin
                if (!tmo) ref_mem[a] = d;
            end else if (tmo) begin
                m_dout = 32'h0;
            end else begin
                m_dout = ref_mem.exists(a) ? ref_mem[a] : deflt(a);
            end
        end
        t0 = txn;
        MemRead  = rd;
        MemWrite = wr;
        Addr     = a;
        Din      = d;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (!Stall) break;
            stalls++;
            if (bus.mem_req) begin
                if (reqs == 0) begin
                    cap_we    = bus.mem_we;
                    cap_addr  = bus.mem_addr;
                    cap_wdata = bus.mem_wdata;
                end
                if (reqs == waits) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        bus_mem[bus.mem_addr] = bus.mem_wdata;
                    end else begin
                        rv = bus_mem.exists(bus.mem_addr)
                           ? bus_mem[bus.mem_addr] : deflt(bus.mem_addr);
                        bus.mem_rdata = rv;
                    end
                end
                reqs++;
            end
            @(posedge clock);
            #1;
        end
        if (!(acc && al)) begin
            @(posedge clock);
            #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            @(negedge clock);
        end
        check({tag, ".stall"}, stalls, (exp_req > 0) ? exp_req + 1 : 0);
        check({tag, ".reqs"}, reqs, exp_req);
        check({tag, ".txn"}, txn - t0, (acc && al) ? 1 : 0);
        check({tag, ".req_low"}, bus.mem_req, 1'b0);
        if (exp_req > 0) begin
            check({tag, ".we"}, cap_we, wr);
            check({tag, ".addr"}, cap_addr, a);
            if (wr) check({tag, ".wdata"}, cap_wdata, d);
        end
        check({tag, ".dout"}, Dout, m_dout);
        check({tag, ".alignerr"}, AlignErr, m_align);
        check({tag, ".buserr"}, BusErr, m_bus);
        @(posedge clock);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [31:0] a;
        int          r;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset with an access pending: Stall must stay low.
        MemRead = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst.stall", Stall, 1'b0);
        check("rst.dout", Dout, 32'h0);
        check("rst.req", bus.mem_req, 1'b0);
        check("rst.we", bus.mem_we, 1'b0);
        check("rst.addr", bus.mem_addr, 32'h0);
        check("rst.wdata", bus.mem_wdata, 32'h0);
        check("rst.alignerr", AlignErr, 1'b0);
        check("rst.buserr", BusErr, 1'b0);
        reset   = 1'b0;
        MemRead = 1'b0;
        @(posedge clock);
        #1;

        bus_mem[32'h8] = 32'h9;
        ref_mem[32'h8] = 32'h9;
        do_access(1'b1, 1'b0, 32'h8, 32'h0, 0, "ld_ack0");
        do_access(1'b0, 1'b1, 32'h4, 32'h7, 3, "st_wait3");
        do_access(1'b1, 1'b0, 32'h6, 32'h0, 0, "ld_misaligned");
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 9, "ld_timeout");
        do_access(1'b1, 1'b0, 32'h4, 32'h0, 1, "ld_after_tmo");
        do_access(1'b1, 1'b1, 32'hC, 32'h55, 0, "rw_conflict");
        do_access(1'b0, 1'b1, 32'h8, 32'h1, 0, "b2b_st");
        do_access(1'b1, 1'b0, 32'h8, 32'h0, 0, "b2b_ld");
        do_access(1'b0, 1'b0, 32'h8, 32'h0, 0, "no_access");

        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r == 1) || (r >= 2 && r < 6);
            wr = (r == 1) || (r >= 6);
            a  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if (r != 1 && $urandom_range(0, 4) == 0) begin
                a[1:0] = 2'($urandom_range(1, 3));
            end
            do_access(rd, wr, a, $urandom, $urandom_range(0, 5), "rand");
        end

        // Make Dout nonzero, then reset in the second REQ cycle.
        do_access(1'b1, 1'b0, 32'h8, 32'h0, 0, "pre_rst_ld");
        MemRead = 1'b1;
        Addr    = 32'h10;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("midrst.req1", bus.mem_req, 1'b1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("midrst.req2", bus.mem_req, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("midrst.req", bus.mem_req, 1'b0);
        check("midrst.stall", Stall, 1'b0);
        check("midrst.dout", Dout, 32'h0);
        check("midrst.we", bus.mem_we, 1'b0);
        check("midrst.addr", bus.mem_addr, 32'h0);
        check("midrst.alignerr", AlignErr, 1'b0);
        check("midrst.buserr", BusErr, 1'b0);
        m_dout  = 32'h0;
        m_align = 1'b0;
        m_bus   = 1'b0;
        reset         = 1'b0;
        MemRead       = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clock);
        check("lateack.dout", Dout, 32'h0);
        check("lateack.req", bus.mem_req, 1'b0);
        check("lateack.stall", Stall, 1'b0);
        @(posedge clock);
        #1;
        do_access(1'b1, 1'b0, 32'h4, 32'h0, 2, "post_rst_ld");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Load/store unit that sits between the single-cycle processor's data-memory port (MemRead, MemWrite, Addr, Din, Dout) and a multi-cycle data memory with a req/ack handshake.
- Acts as the initiator toward memory. Each processor access becomes exactly one bus transaction.
- Holds the processor with Stall until the transaction completes, and flags misaligned, conflicting or timed-out accesses.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum REQ cycles without mem_ack before the access is aborted (must be ≥ 2).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  processor load request.
- MemWrite  in  1  processor store request.
- Addr  in  AW  processor byte address.
- Din  in  DW  processor store data.
- Dout  out  DW  load data returned to the processor (registered).
- Stall  out  1  freeze processor PC/regfile while high.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  1 = write, 0 = read (registered, valid with mem_req).
- mem_addr  out  AW  word-aligned byte address (registered).
- mem_wdata  out  DW  write data (registered).
- mem_ack  in  1  memory completion; single-cycle pulse while mem_req is high.
- mem_rdata  in  DW  read data, valid with mem_ack.
- AlignErr  out  1  sticky: misaligned access seen.
- BusErr  out  1  sticky: timeout or MemRead & MemWrite together.

Behaviour:
- Reset values (synchronous, checked on the edge where reset = 1):
  - state = IDLE; Dout = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; timeout counter = 0; AlignErr = 0; BusErr = 0.
  - Reset dominates everything. Reset during REQ drops mem_req on the next edge; any late mem_ack is ignored.
- An access means MemRead | MemWrite. Aligned means Addr[1:0] == 0.
- Stall is combinational: (state == IDLE & access & aligned) | (state == REQ). Stall is 0 in DONE and during reset.
- FSM:
  - IDLE, aligned access → REQ. Latch mem_addr = Addr, mem_wdata = Din, mem_we = MemWrite; set mem_req = 1. Counter cleared.
  - IDLE, misaligned access → DONE. No bus transaction, Stall stays 0, AlignErr set; a store is dropped, a load leaves Dout unchanged.
  - IDLE, no access → IDLE.
  - REQ, mem_ack = 1 → DONE. mem_req cleared. If it was a read, Dout = mem_rdata.
  - REQ, no ack, counter == TIMEOUT-1 → DONE. mem_req cleared, BusErr set, Dout = 0 if it was a read.
  - REQ otherwise → REQ; counter increments.
  - DONE → IDLE unconditionally. This one cycle with Stall = 0 lets the processor commit and advance its PC, so the same access is never reissued.
- MemRead & MemWrite together: treated as a write (mem_we = 1) and BusErr set.
- mem_ack outside REQ is ignored.
- The processor holds Addr, Din, MemRead and MemWrite stable while Stall = 1. The LSU uses only latched copies after IDLE.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle): 2 stall cycles per access (IDLE + REQ).
  - N wait states: 2 + N stall cycles.
  - Back-to-back accesses are separated by the DONE cycle.
- AlignErr and BusErr clear only on reset.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  - the read-abort value 32'h0;
  - default TIMEOUT.
- One natural sub-module: lsu_timeout_ctr. It is a clearable, enabled counter with a terminal-count output, so it can be reused for an instruction-side fetch unit later.

Test Plan:
- Load, ack on the first REQ cycle: Addr = 0x8, MemRead, mem_rdata = 0x9.
  - mem_req high for exactly 1 cycle with mem_we = 0 and mem_addr = 0x8.
  - Stall high for 2 cycles; Dout = 0x9 in DONE.
- Store with 3 wait states: Addr = 0x4, Din = 0x7, MemWrite.
  - mem_we = 1, mem_wdata = 0x7, Stall high for 5 cycles.
  - mem_req falls the edge after ack; no errors.
- Misaligned load, Addr = 0x6: no mem_req, Stall = 0, AlignErr = 1 the next cycle, Dout unchanged.
- Timeout with TIMEOUT = 4 and mem_ack never asserted:
  - mem_req high for 4 cycles, then DONE.
  - BusErr = 1, Dout = 0.
  - The next access still completes normally.
- Reset asserted in the 2nd REQ cycle:
  - mem_req = 0 on the next edge and all outputs at reset values.
  - A mem_ack one cycle later causes no Dout change.
- Back-to-back store then load (sw 0x8 = 0x1, then lw 0x8 with memory echoing the stored value):
  - exactly two transactions, separated by one DONE cycle;
  - Dout = 0x1; the DONE cycle prevents a duplicate request.
